// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one combinational sprite ROM port among NUM_REQ
// pixel requesters; two-stage pipeline (address reg, response reg) with backpressure.
`timescale 1ns/1ps
module sprite_rom_arbiter #(
    parameter int          NUM_REQ         = 4,
    parameter int          SPRITE_W        = 16,
    parameter int          SPRITE_H        = 16,
    parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F,
    localparam int         XW              = $clog2(SPRITE_W),
    localparam int         YW              = $clog2(SPRITE_H),
    localparam int         IDW             = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*XW-1:0] req_sx,
    input  logic [NUM_REQ*YW-1:0] req_sy,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [XW-1:0]         rom_sx,
    output logic [YW-1:0]         rom_sy,
    input  logic [11:0]           rom_rgb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [11:0]           rsp_rgb,
    output logic                  rsp_transp
);

    logic [XW-1:0]  sx_arr  [NUM_REQ];
    logic [YW-1:0]  sy_arr  [NUM_REQ];
    logic           oob_arr [NUM_REQ];

    logic [XW-1:0]  rom_sx_q, rom_sx_d;
    logic [YW-1:0]  rom_sy_q, rom_sy_d;
    logic [IDW-1:0] a_id_q, a_id_d;
    logic           a_valid_q, a_valid_d;
    logic           a_oob_q, a_oob_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [11:0]    rsp_rgb_q, rsp_rgb_d;
    logic           rsp_transp_q, rsp_transp_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           b_load;
    logic           can_accept;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   scan_idx;

    // Range check is done in 32 bits so power-of-2 sizes collapse cleanly to "never".
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign sx_arr[gi]    = req_sx[gi*XW +: XW];
            assign sy_arr[gi]    = req_sy[gi*YW +: YW];
            assign oob_arr[gi]   = (32'(sx_arr[gi]) >= SPRITE_W) || (32'(sy_arr[gi]) >= SPRITE_H);
            assign req_ready[gi] = grant_found && (grant_id == IDW'(gi));
        end
    endgenerate

    assign b_load     = a_valid_q && (!rsp_valid_q || rsp_ready);
    assign can_accept = !a_valid_q || b_load;

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
        if (!can_accept || reset) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        rom_sx_d     = rom_sx_q;
        rom_sy_d     = rom_sy_q;
        a_id_d       = a_id_q;
        a_valid_d    = a_valid_q;
        a_oob_d      = a_oob_q;
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_rgb_d    = rsp_rgb_q;
        rsp_transp_d = rsp_transp_q;

        if (grant_found) begin
            rom_sx_d  = sx_arr[grant_id];
            rom_sy_d  = sy_arr[grant_id];
            a_id_d    = grant_id;
            a_oob_d   = oob_arr[grant_id];
            a_valid_d = 1'b1;
            ptr_d     = (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
        end else if (b_load) begin
            a_valid_d = 1'b0;
        end

        if (b_load) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = a_id_q;
            rsp_rgb_d    = a_oob_q ? TRANSPARENT_RGB : rom_rgb;
            rsp_transp_d = (rsp_rgb_d == TRANSPARENT_RGB);
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_sx_q     <= '0;
            rom_sy_q     <= '0;
            a_id_q       <= '0;
            a_valid_q    <= 1'b0;
            a_oob_q      <= 1'b0;
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_rgb_q    <= '0;
            rsp_transp_q <= 1'b0;
        end else begin
            rom_sx_q     <= rom_sx_d;
            rom_sy_q     <= rom_sy_d;
            a_id_q       <= a_id_d;
            a_valid_q    <= a_valid_d;
            a_oob_q      <= a_oob_d;
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_rgb_q    <= rsp_rgb_d;
            rsp_transp_q <= rsp_transp_d;
        end
    end

    assign rom_sx     = rom_sx_q;
    assign rom_sy     = rom_sy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_rgb    = rsp_rgb_q;
    assign rsp_transp = rsp_transp_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (16-wide and 12-wide sprites) share
// stimulus; a scoreboard per instance predicts grants and tagged responses.
`timescale 1ns/1ps
module tb_sprite_rom_arbiter;

    localparam int NR = 4;
    localparam logic [11:0] TKEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid;
    logic [3:0]  sx_arr [NR];
    logic [3:0]  sy_arr [NR];
    logic [15:0] req_sx, req_sy;
    logic        rsp_ready;
    logic [11:0] mem [256];

    logic [3:0]  req_ready_w  [2];
    logic [3:0]  rom_sx_w     [2];
    logic [3:0]  rom_sy_w     [2];
    logic [11:0] rom_rgb_w    [2];
    logic        rsp_valid_w  [2];
    logic [1:0]  rsp_id_w     [2];
    logic [11:0] rsp_rgb_w    [2];
    logic        rsp_transp_w [2];

    typedef struct {
        int          id;
        logic [11:0] rgb;
        logic        transp;
        int          cyc;
    } exp_t;

    exp_t sb [2][$];
    int   ptr_m [2];
    int   dut_w [2] = '{16, 12};
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rst_prev = 1'b0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_pack
            assign req_sx[gi*4 +: 4] = sx_arr[gi];
            assign req_sy[gi*4 +: 4] = sy_arr[gi];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            assign rom_rgb_w[gi] = mem[{rom_sy_w[gi], rom_sx_w[gi]}];
            sprite_rom_arbiter #(
                .NUM_REQ(NR), .SPRITE_W((gi == 0) ? 16 : 12), .SPRITE_H(16), .TRANSPARENT_RGB(TKEY)
            ) u_dut (
                .clk(clk), .reset(reset),
                .req_valid(req_valid), .req_sx(req_sx), .req_sy(req_sy),
                .req_ready(req_ready_w[gi]),
                .rom_sx(rom_sx_w[gi]), .rom_sy(rom_sy_w[gi]), .rom_rgb(rom_rgb_w[gi]),
                .rsp_valid(rsp_valid_w[gi]), .rsp_ready(rsp_ready),
                .rsp_id(rsp_id_w[gi]), .rsp_rgb(rsp_rgb_w[gi]), .rsp_transp(rsp_transp_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
        end
    endtask

    // Expected pixel for a request: out-of-range reads come back as the colour key.
    function automatic logic [11:0] pix(input int d, input int x, input int y);
        if (x >= dut_w[d] || y >= 16) return TKEY;
        return mem[y*16 + x];
    endfunction

    task automatic model_step(input int d);
        logic [3:0]  exp_rdy;
        logic [11:0] p;
        exp_t        e;
        int          gid;
        bit          can;
        bit          exp_v;
        exp_rdy = '0;
        gid     = -1;
        // Pipeline holds at most two items; a full pipe frees a slot only if the head leaves.
        can = (sb[d].size() < 2) || rsp_ready;
        if (can) begin
            for (int k = 0; k < NR; k++) begin
                if (gid < 0 && req_valid[(ptr_m[d] + k) % NR]) gid = (ptr_m[d] + k) % NR;
            end
        end
        if (gid >= 0) exp_rdy[gid] = 1'b1;
        chk("grant", d, 32'(req_ready_w[d]), 32'(exp_rdy));

        exp_v = (sb[d].size() > 0) && (sb[d][0].cyc + 2 <= cyc);
        chk("rsp_valid", d, 32'(rsp_valid_w[d]), 32'(exp_v));
        if (exp_v && rsp_valid_w[d]) begin
            chk("rsp_id", d, 32'(rsp_id_w[d]), 32'(sb[d][0].id));
            chk("rsp_rgb", d, 32'(rsp_rgb_w[d]), 32'(sb[d][0].rgb));
            chk("rsp_transp", d, 32'(rsp_transp_w[d]), 32'(sb[d][0].transp));
            if (rsp_ready) begin
                $display("rsp dut%0d cyc=%0d id=%0d rgb=%03h transp=%0d",
                         d, cyc, rsp_id_w[d], rsp_rgb_w[d], rsp_transp_w[d]);
                void'(sb[d].pop_front());
            end
        end

        if (gid >= 0) begin
            p        = pix(d, int'(sx_arr[gid]), int'(sy_arr[gid]));
            e.id     = gid;
            e.rgb    = p;
            e.transp = (p == TKEY);
            e.cyc    = cyc;
            sb[d].push_back(e);
            ptr_m[d] = (gid + 1) % NR;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst_prev) begin
                chk("rst_rsp_valid", d, 32'(rsp_valid_w[d]), 32'd0);
                chk("rst_rom_sx", d, 32'(rom_sx_w[d]), 32'd0);
                chk("rst_rom_sy", d, 32'(rom_sy_w[d]), 32'd0);
                chk("rst_rsp_id", d, 32'(rsp_id_w[d]), 32'd0);
                chk("rst_rsp_rgb", d, 32'(rsp_rgb_w[d]), 32'd0);
                chk("rst_rsp_transp", d, 32'(rsp_transp_w[d]), 32'd0);
            end
            if (reset) begin
                chk("rst_ready", d, 32'(req_ready_w[d]), 32'd0);
                sb[d].delete();
                ptr_m[d] = 0;
            end else begin
                model_step(d);
            end
        end
        rst_prev = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic rand_coords();
        for (int i = 0; i < NR; i++) begin
            sx_arr[i] = 4'($urandom_range(0, 15));
            sy_arr[i] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = ($urandom_range(0, 7) == 0) ? TKEY : 12'($urandom);
        end
        mem[4*16 + 7] = TKEY;
        mem[4*16 + 8] = 12'h0F0;
        mem[5*16 + 3] = 12'h123;
        for (int i = 0; i < NR; i++) begin
            sx_arr[i] = '0;
            sy_arr[i] = '0;
        end
        rsp_ready = 1'b1;

        // Reset with every requester asserting valid.
        req_valid = 4'hF;
        do_reset(3);
        req_valid = 4'h0;
        tick();

        // Single request from requester 2 at (3,5).
        sx_arr[2] = 4'd3;
        sy_arr[2] = 4'd5;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'h0;
        repeat (4) tick();

        // Round-robin from a fresh pointer, all requesters valid.
        do_reset(1);
        req_valid = 4'hF;
        repeat (8) begin
            rand_coords();
            tick();
        end
        req_valid = 4'h0;
        repeat (4) tick();

        // Backpressure: three request cycles into a stalled consumer.
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        repeat (3) tick();
        req_valid = 4'h0;
        repeat (5) tick();
        rsp_ready = 1'b1;
        repeat (4) tick();

        // Transparent pixel and its opaque neighbour.
        sx_arr[0] = 4'd7; sy_arr[0] = 4'd4;
        sx_arr[1] = 4'd8; sy_arr[1] = 4'd4;
        req_valid = 4'b0011;
        repeat (2) tick();
        req_valid = 4'h0;
        repeat (4) tick();

        // Out-of-range x on the 12-wide instance, then reset during a stall.
        sx_arr[3] = 4'd13; sy_arr[3] = 4'd2;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        repeat (3) tick();
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        repeat (3) tick();
        do_reset(2);
        rsp_ready = 1'b1;
        repeat (4) tick();

        // Randomized traffic with random backpressure.
        repeat (400) begin
            req_valid = 4'($urandom);
            rand_coords();
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        repeat (6) tick();

        for (int d = 0; d < 2; d++) begin
            chk("drained", d, 32'(sb[d].size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
